// File: rtl/lcd_hd44780_driver_pkg.sv
// Shared constants for the HD44780 4-bit driver: pin positions, commands,
// the power-up init table and FSM state encodings.
package lcd_hd44780_driver_pkg;

  localparam int LCD_RS = 5;
  localparam int LCD_E  = 4;

  localparam logic [7:0] CMD_CLEAR     = 8'h01;
  localparam logic [7:0] CMD_HOME      = 8'h02;
  localparam logic [7:0] CMD_FUNC_4B2L = 8'h28;
  localparam logic [7:0] CMD_DISP_ON   = 8'h0C;
  localparam logic [7:0] CMD_ENTRY_INC = 8'h06;
  localparam logic [7:0] CMD_DDRAM_L2  = 8'hC0;

  localparam int INIT_STEPS  = 8;
  localparam int NIB_STEPS   = 4;
  localparam int T_INIT0_US  = 4100;
  localparam int T_INITN_US  = 100;

  typedef enum logic [3:0] {
    PWR_WAIT, IDLE, HI_SET, HI_E, HI_HOLD, LO_SET, LO_E, LO_HOLD, POST_WAIT
  } state_t;

  // Nibble-only steps carry their nibble in the high half; the low half is never sent.
  function automatic logic [7:0] init_byte(input logic [2:0] step);
    case (step)
      3'd0, 3'd1, 3'd2: return 8'h30;
      3'd3:             return 8'h20;
      3'd4:             return CMD_FUNC_4B2L;
      3'd5:             return CMD_DISP_ON;
      3'd6:             return CMD_CLEAR;
      default:          return CMD_ENTRY_INC;
    endcase
  endfunction

  function automatic int max_of(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/lcd_delay_timer.sv
// Shared microsecond down-counter: load with a us count, expire pulses for one
// cycle at the end of the loaded interval (interval = us*CLK_MHZ cycles).
module lcd_delay_timer #(
  parameter int CLK_MHZ = 100,
  parameter int US_W    = 15,
  parameter int CNT_W   = 21
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic [US_W-1:0] us,
  output logic            expire
);

  logic [CNT_W-1:0] cnt;
  logic             run;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      run <= 1'b0;
    end else if (load) begin
      cnt <= CNT_W'(us) * CNT_W'(CLK_MHZ) - CNT_W'(1);
      run <= 1'b1;
    end else if (run) begin
      if (cnt == '0) run <= 1'b0;
      else           cnt <= cnt - CNT_W'(1);
    end
  end

  assign expire = run && (cnt == '0);

endmodule

// File: rtl/lcd_hd44780_driver.sv
// HD44780 4-bit mode driver: runs power-up init, then writes accepted bytes as
// two E-strobed nibbles followed by a busy wait.
module lcd_hd44780_driver
  import lcd_hd44780_driver_pkg::*;
#(
  parameter int CLK_MHZ    = 100,
  parameter int T_PWRUP_US = 20000,
  parameter int T_NIB_US   = 1,
  parameter int T_CMD_US   = 50,
  parameter int T_CLR_US   = 2000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       char_valid,
  input  logic       char_rs,
  input  logic [7:0] char_data,
  output logic       char_ready,
  output logic       init_done,
  output logic [5:0] lcd
);

  localparam int MAX_US = max_of(T_PWRUP_US, T_CLR_US, T_INIT0_US, T_CMD_US);
  localparam int US_W   = $clog2(MAX_US + 1);
  localparam int CNT_W  = $clog2(MAX_US * CLK_MHZ + 1);

  state_t          state, state_n;
  logic [2:0]      step, step_n;
  logic            done_n, pwr_armed;
  logic            rs_q, wr_rs, ld_byte;
  logic [7:0]      byte_q, wr_byte;
  logic [5:0]      lcd_n;
  logic            tload, expire, accept;
  logic [US_W-1:0] tus, wait_us;

  function automatic logic [5:0] pins(input logic rs, input logic e, input logic [3:0] d);
    logic [5:0] p;
    p         = '0;
    p[LCD_RS] = rs;
    p[LCD_E]  = e;
    p[3:0]    = d;
    return p;
  endfunction

  lcd_delay_timer #(.CLK_MHZ(CLK_MHZ), .US_W(US_W), .CNT_W(CNT_W)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (tload),
    .us     (tus),
    .expire (expire)
  );

  // char_ready is only ever high in IDLE after init, so this implies state==IDLE.
  assign accept = char_valid && char_ready;

  always_comb begin
    wait_us = US_W'(T_CMD_US);
    if (!init_done) begin
      case (step)
        3'd0:             wait_us = US_W'(T_INIT0_US);
        3'd1, 3'd2, 3'd3: wait_us = US_W'(T_INITN_US);
        3'd6:             wait_us = US_W'(T_CLR_US);
        default:          wait_us = US_W'(T_CMD_US);
      endcase
    end else if (!rs_q && (byte_q == CMD_CLEAR || byte_q == CMD_HOME)) begin
      wait_us = US_W'(T_CLR_US);
    end
  end

  always_comb begin
    state_n = state;
    step_n  = step;
    done_n  = init_done;
    lcd_n   = lcd;
    tload   = 1'b0;
    tus     = US_W'(T_NIB_US);
    ld_byte = 1'b0;
    wr_rs   = 1'b0;
    wr_byte = init_byte(3'd0);
    case (state)
      PWR_WAIT:
        if (!pwr_armed) begin
          tload = 1'b1;
          tus   = US_W'(T_PWRUP_US);
        end else if (expire) begin
          state_n = HI_SET;
          tload   = 1'b1;
          ld_byte = 1'b1;
          lcd_n   = pins(1'b0, 1'b0, wr_byte[7:4]);
        end
      IDLE:
        if (accept) begin
          wr_rs   = char_rs;
          wr_byte = char_data;
          ld_byte = 1'b1;
          tload   = 1'b1;
          state_n = HI_SET;
          lcd_n   = pins(char_rs, 1'b0, char_data[7:4]);
        end
      HI_SET:
        if (expire) begin
          state_n = HI_E;
          tload   = 1'b1;
          lcd_n   = pins(rs_q, 1'b1, byte_q[7:4]);
        end
      HI_E:
        if (expire) begin
          state_n = HI_HOLD;
          tload   = 1'b1;
          lcd_n   = pins(rs_q, 1'b0, byte_q[7:4]);
        end
      HI_HOLD:
        if (expire) begin
          tload = 1'b1;
          if (!init_done && step < 3'(NIB_STEPS)) begin
            state_n = POST_WAIT;
            tus     = wait_us;
          end else begin
            state_n = LO_SET;
            lcd_n   = pins(rs_q, 1'b0, byte_q[3:0]);
          end
        end
      LO_SET:
        if (expire) begin
          state_n = LO_E;
          tload   = 1'b1;
          lcd_n   = pins(rs_q, 1'b1, byte_q[3:0]);
        end
      LO_E:
        if (expire) begin
          state_n = LO_HOLD;
          tload   = 1'b1;
          lcd_n   = pins(rs_q, 1'b0, byte_q[3:0]);
        end
      LO_HOLD:
        if (expire) begin
          state_n = POST_WAIT;
          tload   = 1'b1;
          tus     = wait_us;
        end
      POST_WAIT:
        if (expire) begin
          if (init_done) begin
            state_n = IDLE;
          end else if (step == 3'(INIT_STEPS - 1)) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            step_n  = step + 3'd1;
            wr_byte = init_byte(step + 3'd1);
            ld_byte = 1'b1;
            tload   = 1'b1;
            state_n = HI_SET;
            lcd_n   = pins(1'b0, 1'b0, wr_byte[7:4]);
          end
        end
      default: state_n = PWR_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= PWR_WAIT;
      step       <= '0;
      init_done  <= 1'b0;
      pwr_armed  <= 1'b0;
      rs_q       <= 1'b0;
      byte_q     <= '0;
      lcd        <= '0;
      char_ready <= 1'b0;
    end else begin
      state      <= state_n;
      step       <= step_n;
      init_done  <= done_n;
      pwr_armed  <= 1'b1;
      lcd        <= lcd_n;
      char_ready <= (state_n == IDLE) && done_n;
      if (ld_byte) begin
        rs_q   <= wr_rs;
        byte_q <= wr_byte;
      end
    end
  end

endmodule

// File: tb/tb_lcd_hd44780_driver.sv
// Directed bench for lcd_hd44780_driver at CLK_MHZ=1 (1 cycle = 1 us).
module tb_lcd_hd44780_driver;
  import lcd_hd44780_driver_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       char_valid = 1'b0;
  logic       char_rs = 1'b0;
  logic [7:0] char_data = 8'h00;
  logic       char_ready, init_done;
  logic [5:0] lcd;

  lcd_hd44780_driver #(.CLK_MHZ(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .char_valid (char_valid),
    .char_rs    (char_rs),
    .char_data  (char_data),
    .char_ready (char_ready),
    .init_done  (init_done),
    .lcd        (lcd)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct { int cyc; logic rs; logic [3:0] d; } ev_t;
  ev_t  ev_q[$];
  logic prev_e = 1'b0;

  // Record every E rising edge with the bus contents it strobes.
  always @(negedge clk) begin
    ev_t e;
    if (lcd[LCD_E] && !prev_e) begin
      e.cyc = cyc;
      e.rs  = lcd[LCD_RS];
      e.d   = lcd[3:0];
      ev_q.push_back(e);
    end
    prev_e = lcd[LCD_E];
  end

  typedef struct { logic rs; logic [7:0] data; int busy; } vec_t;
  vec_t vt [8];
  int   init_nib [12] = '{3, 3, 3, 2, 2, 8, 0, 12, 0, 1, 0, 6};
  int   init_gap [4]  = '{4103, 103, 103, 103};

  int n_err = 0;
  int n_chk = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string name, input int bound, output int waited);
    waited = 0;
    while (char_ready !== 1'b1 && waited < bound) begin
      tick();
      waited++;
    end
    chk({name, "_ready_seen"}, 32'(char_ready), 32'd1);
  endtask

  task automatic check_init(input string tag, input int rel);
    int n, early, dly;
    n = 0;
    early = 0;
    while (init_done !== 1'b1 && n < 40000) begin
      if (char_ready === 1'b1) early++;
      tick();
      n++;
    end
    chk({tag, "_done"}, 32'(init_done), 32'd1);
    chk({tag, "_ready_with_done"}, 32'(char_ready), 32'd1);
    chk({tag, "_early_ready"}, 32'(early), 32'd0);
    chk({tag, "_n_pulses"}, 32'(ev_q.size()), 32'd12);
    if (ev_q.size() == 12) begin
      dly = ev_q[0].cyc - rel;
      n_chk++;
      if (dly < 20000 || dly > 20005) begin
        n_err++;
        $display("FAIL %s_pwrup_delay: got %0d expected 20000..20005", tag, dly);
      end
      for (int i = 0; i < 12; i++) begin
        chk($sformatf("%s_nib%0d", tag, i), 32'(ev_q[i].d), 32'(init_nib[i]));
        chk($sformatf("%s_rs%0d", tag, i), 32'(ev_q[i].rs), 32'd0);
      end
      // E-rise to E-rise between nibble-only steps = wait + 3 nibble phases.
      for (int i = 0; i < 4; i++)
        chk($sformatf("%s_gap%0d", tag, i), 32'(ev_q[i+1].cyc - ev_q[i].cyc), 32'(init_gap[i]));
      chk({tag, "_hi_lo_gap"}, 32'(ev_q[5].cyc - ev_q[4].cyc), 32'd3);
      chk({tag, "_done_time"}, 32'(cyc - ev_q[11].cyc), 32'd52);
    end
  endtask

  initial begin
    int rel, t0, t1, t2, w, n;
    logic [5:0] exp_l;

    vt[0] = '{1'b1, 8'h35, 56};
    vt[1] = '{1'b0, CMD_CLEAR, 2006};
    vt[2] = '{1'b0, CMD_HOME, 2006};
    vt[3] = '{1'b0, CMD_DDRAM_L2, 56};
    vt[4] = '{1'b1, 8'h01, 56};
    vt[5] = '{1'b1, 8'h02, 56};
    vt[6] = '{1'b0, 8'h03, 56};
    vt[7] = '{1'b0, 8'h00, 56};

    // Power-up reset and init sequence
    reset = 1'b0;
    repeat (5) tick();
    chk("rst_lcd", 32'(lcd), 32'd0);
    chk("rst_ready", 32'(char_ready), 32'd0);
    chk("rst_done", 32'(init_done), 32'd0);
    #3 reset = 1'b1;
    rel = cyc;
    check_init("init1", rel);

    // Table-driven single writes
    for (int i = 0; i < 8; i++) begin
      wait_ready($sformatf("v%0d_pre", i), 3000, w);
      ev_q.delete();
      char_valid = 1'b1;
      char_rs    = vt[i].rs;
      char_data  = vt[i].data;
      tick();
      t0 = cyc;
      char_valid = 1'b0;
      chk($sformatf("v%0d_ready_drop", i), 32'(char_ready), 32'd0);
      wait_ready($sformatf("v%0d", i), 3000, w);
      chk($sformatf("v%0d_busy", i), 32'(cyc - t0), 32'(vt[i].busy));
      chk($sformatf("v%0d_n_pulses", i), 32'(ev_q.size()), 32'd2);
      if (ev_q.size() == 2) begin
        chk($sformatf("v%0d_hi", i), 32'(ev_q[0].d), 32'(vt[i].data[7:4]));
        chk($sformatf("v%0d_lo", i), 32'(ev_q[1].d), 32'(vt[i].data[3:0]));
        chk($sformatf("v%0d_rs", i), 32'({ev_q[0].rs, ev_q[1].rs}), 32'({vt[i].rs, vt[i].rs}));
        chk($sformatf("v%0d_first_e", i), 32'(ev_q[0].cyc - t0), 32'd1);
      end
      exp_l = {vt[i].rs, 1'b0, vt[i].data[3:0]};
      chk($sformatf("v%0d_idle_pins", i), 32'(lcd), 32'(exp_l));
    end

    // Clear followed by a byte held valid through the busy time
    ev_q.delete();
    char_valid = 1'b1;
    char_rs    = 1'b0;
    char_data  = CMD_CLEAR;
    tick();
    t0 = cyc;
    char_rs   = 1'b1;
    char_data = 8'h42;
    n = 0;
    while (char_ready !== 1'b1 && n < 3000) begin
      tick();
      n++;
    end
    t1 = cyc;
    chk("t4_clr_busy", 32'(t1 - t0), 32'd2006);
    chk("t4_pulses_before", 32'(ev_q.size()), 32'd2);
    tick();
    t2 = cyc;
    char_valid = 1'b0;
    chk("t4_ready_one_cycle", 32'(char_ready), 32'd0);
    wait_ready("t4_second", 3000, w);
    chk("t4_second_busy", 32'(cyc - t2), 32'd56);
    chk("t4_n_pulses", 32'(ev_q.size()), 32'd4);
    if (ev_q.size() == 4) begin
      chk("t4_nibs", 32'({ev_q[0].d, ev_q[1].d, ev_q[2].d, ev_q[3].d}), 32'h0142);
      chk("t4_rs", 32'({ev_q[0].rs, ev_q[1].rs, ev_q[2].rs, ev_q[3].rs}), 32'b0011);
      chk("t4_second_first_e", 32'(ev_q[2].cyc - t2), 32'd1);
    end

    // Reset while E is high, with a byte held valid through the re-init
    char_valid = 1'b1;
    char_rs    = 1'b1;
    char_data  = 8'h41;
    n = 0;
    while (lcd[LCD_E] !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("t6_e_high", 32'(lcd[LCD_E]), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("t6_async_lcd", 32'(lcd), 32'd0);
    chk("t6_async_ready", 32'(char_ready), 32'd0);
    repeat (3) tick();
    chk("t6_held_lcd", 32'(lcd), 32'd0);
    chk("t6_held_done", 32'(init_done), 32'd0);
    ev_q.delete();
    #3 reset = 1'b1;
    rel = cyc;
    check_init("init2", rel);
    tick();
    t0 = cyc;
    char_valid = 1'b0;
    chk("t5_ready_drop", 32'(char_ready), 32'd0);
    wait_ready("t5", 3000, w);
    chk("t5_busy", 32'(cyc - t0), 32'd56);
    chk("t5_n_pulses", 32'(ev_q.size()), 32'd14);
    if (ev_q.size() == 14) begin
      chk("t5_nibs", 32'({ev_q[12].d, ev_q[13].d}), 32'h41);
      chk("t5_rs", 32'({ev_q[12].rs, ev_q[13].rs}), 32'b11);
      chk("t5_first_e", 32'(ev_q[12].cyc - t0), 32'd1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
